// File: rtl/gpu_line_fetch.sv
// Framebuffer line fetcher: commits the shadow line on refill and prefetches the next line of three 1-bpp planes.
// Define GPU_FB_PIXEL_DOUBLING_EN for a 320-pixel line fetched from line>>1; the default build uses 640 pixels.
module gpu_line_fetch #(
    parameter logic [31:0] FB_BASE     = 32'h0004_0000,
    parameter logic [31:0] PLANE_BYTES = 32'h0000_9600,
`ifdef GPU_FB_PIXEL_DOUBLING_EN
    localparam int W = 320
`else
    localparam int W = 640
`endif
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          refill,
    input  logic [9:0]    line,
    input  logic          enable,
    output logic          mem_valid,
    output logic [31:0]   mem_addr,
    input  logic          mem_ready,
    input  logic [31:0]   mem_rdata,
    output logic [W-1:0]  hline_r,
    output logic [W-1:0]  hline_g,
    output logic [W-1:0]  hline_b,
    output logic          busy,
    output logic          overrun,
    input  logic          clr_overrun
);

    localparam int          WPL        = W / 32;
    localparam int          IW         = $clog2(W);
    localparam logic [31:0] LINE_BYTES = 32'(WPL * 4);
    localparam logic [4:0]  K_LAST     = 5'(WPL - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t      r_state, w_state_next;
    logic [1:0]  r_p, w_p_next;
    logic [4:0]  r_k, w_k_next;
    logic [9:0]  r_src, w_src_next;
    logic [9:0]  r_pend_src;
    logic [9:0]  w_line_src, w_start_src;
    logic        r_pending, w_pending_next;
    logic        r_mem_valid, w_mem_valid_next;
    logic [31:0] r_mem_addr, w_mem_addr_next;
    logic        r_overrun, w_overrun_next;
    logic        w_beat, w_last, w_restart;
    logic [IW-1:0] w_bit_base;

    function automatic logic [31:0] f_addr(input logic [1:0] p, input logic [4:0] k, input logic [9:0] src);
        return FB_BASE + {30'd0, p} * PLANE_BYTES + {22'd0, src} * LINE_BYTES + {25'd0, k, 2'b00};
    endfunction

`ifdef GPU_FB_PIXEL_DOUBLING_EN
    assign w_line_src = 10'(line >> 1);
`else
    assign w_line_src = line;
`endif

    assign w_beat      = r_mem_valid && mem_ready;
    assign w_last      = (r_p == 2'd2) && (r_k == K_LAST);
    assign w_start_src = refill ? w_line_src : r_pend_src;
    assign w_bit_base  = IW'({r_k, 5'd0});

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_p         <= '0;
            r_k         <= '0;
            r_src       <= '0;
            r_pend_src  <= '0;
            r_pending   <= 1'b0;
            r_mem_valid <= 1'b0;
            r_mem_addr  <= '0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_p         <= w_p_next;
            r_k         <= w_k_next;
            r_src       <= w_src_next;
            r_pending   <= w_pending_next;
            r_mem_valid <= w_mem_valid_next;
            r_mem_addr  <= w_mem_addr_next;
            r_overrun   <= w_overrun_next;
            if (refill)
                r_pend_src <= w_line_src;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_p_next         = r_p;
        w_k_next         = r_k;
        w_src_next       = r_src;
        w_pending_next   = r_pending;
        w_mem_valid_next = r_mem_valid;
        w_mem_addr_next  = r_mem_addr;
        w_overrun_next   = r_overrun & ~clr_overrun;
        w_restart        = 1'b0;
        case (r_state)
            IDLE: begin
                if (refill && enable)
                    w_restart = 1'b1;
            end
            FETCH: begin
                if (w_beat) begin
                    if (w_last) begin
                        w_state_next     = IDLE;
                        w_mem_valid_next = 1'b0;
                    end else begin
                        if (r_k == K_LAST) begin
                            w_k_next = '0;
                            w_p_next = r_p + 2'd1;
                        end else begin
                            w_k_next = r_k + 5'd1;
                        end
                        w_mem_addr_next = f_addr(w_p_next, w_k_next, r_src);
                    end
                end
                // A refill landing on the final beat is a clean hand-off, not an overrun.
                if (refill) begin
                    if (!(w_beat && w_last))
                        w_overrun_next = 1'b1;
                    if (enable) begin
                        if (w_beat) begin
                            w_restart = 1'b1;
                        end else begin
                            w_pending_next = 1'b1;
                            w_state_next   = DRAIN;
                        end
                    end
                end
            end
            DRAIN: begin
                if (refill)
                    w_overrun_next = 1'b1;
                if (w_beat && r_pending)
                    w_restart = 1'b1;
            end
            default: w_state_next = IDLE;
        endcase
        if (w_restart) begin
            w_state_next     = FETCH;
            w_p_next         = '0;
            w_k_next         = '0;
            w_src_next       = w_start_src;
            w_pending_next   = 1'b0;
            w_mem_valid_next = 1'b1;
            w_mem_addr_next  = f_addr(2'd0, 5'd0, w_start_src);
        end
    end

    // Commit takes the shadow including any beat landing on the same edge.
    for (genvar gi = 0; gi < 3; gi++) begin : g_plane
        logic [W-1:0] r_shadow, r_hline, w_shadow_next;

        always_comb begin
            w_shadow_next = r_shadow;
            if (w_beat && r_p == 2'(gi))
                w_shadow_next[w_bit_base +: 32] = mem_rdata;
        end

        always_ff @(posedge clk) begin
            if (!resetn) begin
                r_shadow <= '0;
                r_hline  <= '0;
            end else begin
                r_shadow <= w_shadow_next;
                if (refill)
                    r_hline <= w_shadow_next;
            end
        end
    end

    assign hline_r   = g_plane[0].r_hline;
    assign hline_g   = g_plane[1].r_hline;
    assign hline_b   = g_plane[2].r_hline;
    assign mem_valid = r_mem_valid;
    assign mem_addr  = r_mem_addr;
    assign busy      = (r_state != IDLE);
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_gpu_line_fetch.sv
// Self-checking bench for gpu_line_fetch: directed scenarios plus randomized traffic against a beat-index model.
module tb_gpu_line_fetch;

`ifdef GPU_FB_PIXEL_DOUBLING_EN
    localparam int          W         = 320;
    localparam logic [31:0] A_LINE7   = 32'h0004_0078;
    localparam logic [31:0] A_B_LAST7 = 32'h0004_0078 + 32'h0001_2C00 + 32'd36;
    localparam logic [31:0] A_479     = 32'h0004_2558;
    localparam logic [31:0] A_L20_B12 = 32'h0004_9798;
    localparam logic [31:0] A_L40     = 32'h0004_0320;
`else
    localparam int          W         = 640;
    localparam logic [31:0] A_LINE7   = 32'h0004_0230;
    localparam logic [31:0] A_B_LAST7 = 32'h0004_0230 + 32'h0001_2C00 + 32'd76;
    localparam logic [31:0] A_479     = 32'h0004_95B0;
    localparam logic [31:0] A_L20_B12 = 32'h0004_0670;
    localparam logic [31:0] A_L40     = 32'h0004_0C80;
`endif
    localparam int WPL = W / 32;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          refill = 1'b0;
    logic [9:0]    line = '0;
    logic          enable = 1'b1;
    logic          mem_valid;
    logic [31:0]   mem_addr;
    logic          mem_ready = 1'b0;
    logic [31:0]   mem_rdata;
    logic [W-1:0]  hline_r, hline_g, hline_b;
    logic          busy, overrun;
    logic          clr_overrun = 1'b0;

    logic [31:0]   data_xor = '0;
    bit            rand_ready = 1'b0;
    int            ready_pct = 30;
    int            n_vec = 0;
    int            n_err = 0;

    // model state
    bit            m_live = 1'b0;
    bit            m_active, m_pending, m_ov;
    int            m_n;
    logic [9:0]    m_src, m_psrc;
    logic [W-1:0]  m_sh [3];
    logic [W-1:0]  m_hl [3];

    gpu_line_fetch dut (
        .clk(clk), .resetn(resetn), .refill(refill), .line(line), .enable(enable),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .hline_r(hline_r), .hline_g(hline_g), .hline_b(hline_b),
        .busy(busy), .overrun(overrun), .clr_overrun(clr_overrun)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem_addr ^ data_xor;

    function automatic logic [9:0] src_of(input logic [9:0] ln);
`ifdef GPU_FB_PIXEL_DOUBLING_EN
        return ln >> 1;
`else
        return ln;
`endif
    endfunction

    function automatic logic [31:0] m_addr();
        return 32'h0004_0000 + 32'(m_n / WPL) * 32'h9600 + 32'(m_src) * 32'(WPL * 4) + 32'(m_n % WPL) * 32'd4;
    endfunction

    task automatic chk(input string name, input logic [639:0] act, input logic [639:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a fetch is a sequence of 3*WPL beats indexed by m_n.
    always @(posedge clk) begin
        bit beat, done;
        logic [9:0] nsrc;
        if (!resetn) begin
            m_live = 1'b1; m_active = 1'b0; m_pending = 1'b0; m_ov = 1'b0;
            m_n = 0; m_src = '0; m_psrc = '0;
            for (int p = 0; p < 3; p++) begin
                m_sh[p] = '0;
                m_hl[p] = '0;
            end
        end else begin
            nsrc = src_of(line);
            beat = m_active && mem_ready;
            if (beat)
                m_sh[m_n / WPL][(m_n % WPL) * 32 +: 32] = m_addr() ^ data_xor;
            done = beat && !m_pending && (m_n == 3 * WPL - 1);
            if (refill)
                for (int p = 0; p < 3; p++) m_hl[p] = m_sh[p];
            if (refill && m_active && !done) m_ov = 1'b1;
            else if (clr_overrun) m_ov = 1'b0;
            if (m_pending) begin
                if (refill) m_psrc = nsrc;
                if (beat) begin
                    m_pending = 1'b0; m_n = 0; m_src = m_psrc;
                end
            end else if (m_active) begin
                if (beat) begin
                    if (done) m_active = 1'b0;
                    else m_n++;
                end
                if (refill && enable) begin
                    if (beat) begin
                        m_active = 1'b1; m_n = 0; m_src = nsrc;
                    end else begin
                        m_pending = 1'b1; m_psrc = nsrc;
                    end
                end
            end else if (refill && enable) begin
                m_active = 1'b1; m_n = 0; m_src = nsrc;
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("mem_valid", 640'(mem_valid), 640'(m_active));
            chk("busy", 640'(busy), 640'(m_active));
            chk("overrun", 640'(overrun), 640'(m_ov));
            if (m_active) chk("mem_addr", 640'(mem_addr), 640'(m_addr()));
            chk("hline_r", 640'(hline_r), 640'(m_hl[0]));
            chk("hline_g", 640'(hline_g), 640'(m_hl[1]));
            chk("hline_b", 640'(hline_b), 640'(m_hl[2]));
        end
    end

    task automatic tick();
        @(negedge clk);
        if (rand_ready) mem_ready = ($urandom_range(0, 99) < ready_pct);
    endtask

    task automatic do_refill(input logic [9:0] ln);
        line = ln;
        refill = 1'b1;
        tick();
        refill = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        for (int i = 0; i < bound && busy; i++) tick();
        chk("idle_timeout", 640'(busy), 640'(0));
    endtask

    task automatic run_count(output int nbusy, output int nbeat);
        nbusy = 0;
        nbeat = 0;
        for (int i = 0; i < 400 && busy; i++) begin
            nbusy++;
            if (mem_valid && mem_ready) nbeat++;
            tick();
        end
    endtask

    initial begin
        int nb, nbt;
        // reset with refill pulsing
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            refill = i[0];
            tick();
        end
        refill = 1'b0;
        chk("rst_valid", 640'(mem_valid), 640'(0));
        chk("rst_addr", 640'(mem_addr), 640'(0));
        chk("rst_busy", 640'(busy), 640'(0));
        chk("rst_overrun", 640'(overrun), 640'(0));
        chk("rst_hline_r", 640'(hline_r), 640'(0));
        resetn = 1'b1;
        tick();

        // single fetch with mem_ready held high
        do_refill(10'd7);
        chk("first_addr", 640'(mem_addr), 640'(A_LINE7));
        run_count(nb, nbt);
        chk("busy_cycles", 640'(nb), 640'(3 * WPL));
        chk("beat_count", 640'(nbt), 640'(3 * WPL));
        do_refill(10'd7);
        chk("hline_r_w0", 640'(hline_r[31:0]), 640'(A_LINE7));
        chk("hline_g_w0", 640'(hline_g[31:0]), 640'(A_LINE7 + 32'h9600));
        chk("hline_b_wlast", 640'(hline_b[(WPL-1)*32 +: 32]), 640'(A_B_LAST7));
        wait_idle(200);

        // 30% mem_ready duty: same line content expected
        rand_ready = 1'b1;
        ready_pct = 30;
        do_refill(10'd7);
        wait_idle(2000);
        rand_ready = 1'b0;
        mem_ready = 1'b1;
        do_refill(10'd7);
        chk("rnd_hline_r_w0", 640'(hline_r[31:0]), 640'(A_LINE7));
        chk("rnd_hline_b_wlast", 640'(hline_b[(WPL-1)*32 +: 32]), 640'(A_B_LAST7));
        wait_idle(200);

        // overrun while beat 12 is stalled
        do_refill(10'd20);
        repeat (12) tick();
        mem_ready = 1'b0;
        do_refill(10'd40);
        chk("ovr_flag", 640'(overrun), 640'(1));
        chk("ovr_valid_held", 640'(mem_valid), 640'(1));
        chk("ovr_addr_held", 640'(mem_addr), 640'(A_L20_B12));
        repeat (2) tick();
        chk("ovr_addr_held2", 640'(mem_addr), 640'(A_L20_B12));
        mem_ready = 1'b1;
        tick();
        chk("ovr_restart_addr", 640'(mem_addr), 640'(A_L40));
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        chk("ovr_cleared", 640'(overrun), 640'(0));
        wait_idle(200);

        // refill coinciding with the final B beat
        do_refill(10'd7);
        repeat (3 * WPL - 1) tick();
        do_refill(10'd7);
        chk("coll_overrun", 640'(overrun), 640'(0));
        chk("coll_hline_b", 640'(hline_b[(WPL-1)*32 +: 32]), 640'(A_B_LAST7));
        chk("coll_busy", 640'(busy), 640'(1));
        wait_idle(200);

        // line 479
        do_refill(10'd479);
        chk("l479_addr", 640'(mem_addr), 640'(A_479));
        run_count(nb, nbt);
        chk("l479_busy", 640'(nb), 640'(3 * WPL));
        chk("l479_beats", 640'(nbt), 640'(3 * WPL));

        // randomized traffic
        data_xor = $urandom;
        rand_ready = 1'b1;
        ready_pct = 50;
        for (int i = 0; i < 3000; i++) begin
            refill = ($urandom_range(0, 39) == 0);
            line = 10'($urandom_range(0, 1023));
            enable = ($urandom_range(0, 9) != 0);
            clr_overrun = ($urandom_range(0, 29) == 0);
            resetn = ($urandom_range(0, 699) != 0);
            tick();
        end
        refill = 1'b0;
        clr_overrun = 1'b0;
        resetn = 1'b1;
        repeat (5) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
